// File: rtl/sisc_mem_arb_pkg.sv
// rtl/sisc_mem_arb_pkg.sv - shared encodings, defaults and helpers for the SISC memory arbiter
package sisc_mem_arb_pkg;

  // Defaults shared with the ctrl and memory blocks
  localparam int AW_DEF = 16;
  localparam int DW_DEF = 32;

  // Width of the access-latency and starvation counters (both top out at 15)
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } arb_owner_e;

  // Increment that sticks at max_v
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] max_v);
    return (v >= max_v) ? max_v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sisc_mem_arb_prio.sv
// rtl/sisc_mem_arb_prio.sv - combinational winner select between fetch and load/store
module sisc_mem_arb_prio
  import sisc_mem_arb_pkg::*;
(
  input  logic       if_req,
  input  logic       ls_req,
  input  logic       starve_hit,
  output logic       grant_valid,
  output arb_owner_e grant_owner
);

  // LS wins ties unless IF has already waited out its starvation budget
  always_comb begin
    grant_valid = if_req | ls_req;
    grant_owner = OWN_IF;
    if (ls_req && !(if_req && starve_hit)) begin
      grant_owner = OWN_LS;
    end
  end

endmodule

// File: rtl/sisc_mem_arb.sv
// rtl/sisc_mem_arb.sv - single-port memory arbiter between instruction fetch and load/store
module sisc_mem_arb
  import sisc_mem_arb_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  output logic          ls_ack,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] SMAX   = CNT_W'(STARVE_MAX);

  arb_state_e       state_q, state_d;
  arb_owner_e       owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic             we_q, we_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [DW-1:0]    rdata_q, rdata_d;

  logic             grant_valid;
  arb_owner_e       grant_owner;

  sisc_mem_arb_prio u_prio (
    .if_req      (if_req),
    .ls_req      (ls_req),
    .starve_hit  (starve_q == SMAX),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  // Next-state: grant in IDLE, count down the access, then one response cycle
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    starve_d = starve_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          owner_d = grant_owner;
          cnt_d   = LAT_M1;
          state_d = ACCESS;
          if (grant_owner == OWN_LS) begin
            addr_d   = ls_addr;
            we_d     = ls_we;
            wdata_d  = ls_wdata;
            starve_d = if_req ? sat_inc(starve_q, SMAX) : '0;
          end else begin
            addr_d   = if_addr;
            we_d     = 1'b0;
            wdata_d  = '0;
            starve_d = '0;
          end
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          if (!we_q) begin
            rdata_d = mem_rdata;
          end
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset aborts any access in flight without an ack
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q  <= IDLE;
      owner_q  <= OWN_IF;
      cnt_q    <= '0;
      starve_q <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

  assign mem_en    = (state_q == ACCESS);
  assign mem_we    = (state_q == ACCESS) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;
  assign if_ack    = (state_q == RESP) && (owner_q == OWN_IF);
  assign ls_ack    = (state_q == RESP) && (owner_q == OWN_LS);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sisc_mem_arb.sv
// tb/tb_sisc_mem_arb.sv - self-checking bench for sisc_mem_arb
module tb_sisc_mem_arb;

  localparam int AW         = 16;
  localparam int DW         = 32;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 3;

  logic          clk = 1'b0;
  logic          rst_f;
  logic          if_req, ls_req, ls_we;
  logic [AW-1:0] if_addr, ls_addr, mem_addr;
  logic [DW-1:0] ls_wdata, mem_wdata, mem_rdata, rdata;
  logic          if_ack, ls_ack, mem_en, mem_we, busy;

  logic [DW-1:0] bmem   [0:65535];
  logic [DW-1:0] shadow [0:65535];

  int checks = 0;
  int errors = 0;
  int n = 0;

  // Transaction-level reference: one outstanding access, timed from its grant edge
  bit            m_active;
  int            m_g;
  bit            m_own;
  logic [AW-1:0] m_addr;
  bit            m_we;
  logic [DW-1:0] m_wdata, m_rdata;
  int            m_starve;

  bit ack_log[$];

  always #5 clk = ~clk;

  assign mem_rdata = bmem[mem_addr];

  sisc_mem_arb #(
    .AW(AW), .DW(DW), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst_f(rst_f),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_ack(ls_ack),
    .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, n, act, exp);
    end
  endtask

  task automatic m_reset();
    m_active = 0;
    m_own    = 0;
    m_addr   = '0;
    m_we     = 0;
    m_wdata  = '0;
    m_rdata  = '0;
    m_starve = 0;
  endtask

  // Apply one clock edge to the model using the inputs that edge saw
  task automatic m_advance();
    bit was_idle;
    bit ls_win;
    if (!rst_f) begin
      m_reset();
      return;
    end
    was_idle = !m_active;
    if (m_active) begin
      if (n - m_g == MEM_LAT) begin
        if (m_we) shadow[m_addr] = m_wdata;
        else      m_rdata = shadow[m_addr];
      end
      if (n - m_g == MEM_LAT + 1) m_active = 0;
    end
    if (was_idle && (if_req || ls_req)) begin
      ls_win   = ls_req && !(if_req && m_starve == STARVE_MAX);
      m_active = 1;
      m_g      = n;
      m_own    = ls_win;
      if (ls_win) begin
        m_addr   = ls_addr;
        m_we     = ls_we;
        m_wdata  = ls_wdata;
        m_starve = if_req ? ((m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX) : 0;
      end else begin
        m_addr   = if_addr;
        m_we     = 0;
        m_wdata  = '0;
        m_starve = 0;
      end
    end
  endtask

  // One cycle: advance model, compare every output, service bench memory writes
  task automatic cyc();
    int age;
    bit e_en, e_ack;
    @(negedge clk);
    n++;
    m_advance();
    age   = n - m_g;
    e_en  = m_active && (age < MEM_LAT);
    e_ack = m_active && (age == MEM_LAT);
    chk("if_ack", if_ack, e_ack && !m_own);
    chk("ls_ack", ls_ack, e_ack && m_own);
    chk("mem_en", mem_en, e_en);
    chk("mem_we", mem_we, e_en && m_we);
    chk("busy", busy, m_active);
    chk("mem_addr", mem_addr, m_addr);
    chk("rdata", rdata, m_rdata);
    if ((e_en && m_we) || !rst_f) chk("mem_wdata", mem_wdata, m_wdata);
    chk("ack_excl", if_ack && ls_ack, 0);
    if (if_ack) ack_log.push_back(1'b0);
    if (ls_ack) ack_log.push_back(1'b1);
    if (mem_en && mem_we) bmem[mem_addr] = mem_wdata;
  endtask

  task automatic xfer(input bit is_ls, input bit we, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, output int lat, output int en_cnt,
                      output int we_cnt);
    int k, lim;
    bit done;
    k = n; en_cnt = 0; we_cnt = 0; lim = 30; done = 0;
    if (is_ls) begin
      ls_req = 1; ls_we = we; ls_addr = a; ls_wdata = d;
    end else begin
      if_req = 1; if_addr = a;
    end
    while (!done && lim > 0) begin
      cyc();
      lim--;
      if (mem_en) begin
        en_cnt++;
        chk("xfer_addr", mem_addr, a);
      end
      if (mem_we) we_cnt++;
      if (is_ls ? ls_ack : if_ack) done = 1;
    end
    chk("xfer_done", done, 1);
    lat = n - k;
    if_req = 0;
    ls_req = 0;
  endtask

  task automatic run_acks(input int cnt, input bit hold_if, input bit hold_ls);
    int limit, got;
    limit = cnt * (MEM_LAT + 2) + 20;
    got   = 0;
    ack_log.delete();
    while (got < cnt && limit > 0) begin
      cyc();
      limit--;
      if (if_ack) begin got++; if (!hold_if) if_req = 0; end
      if (ls_ack) begin got++; if (!hold_ls) ls_req = 0; end
    end
    chk("ack_count", got, cnt);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cycle %0d: got timeout expected finish", n);
    $fatal(1);
  end

  initial begin
    int lat, en_cnt, we_cnt;
    int k;
    bit exp_order [8];
    exp_order = '{1, 1, 1, 0, 1, 1, 1, 0};

    for (int i = 0; i < 65536; i++) begin
      bmem[i]   = 32'(i) * 32'h9E3779B1;
      shadow[i] = 32'(i) * 32'h9E3779B1;
    end
    bmem[16'h0010] = 32'hDEADBEEF; shadow[16'h0010] = 32'hDEADBEEF;
    bmem[16'h0040] = 32'hCAFEF00D; shadow[16'h0040] = 32'hCAFEF00D;

    rst_f = 0; if_req = 0; ls_req = 0; ls_we = 0;
    if_addr = '0; ls_addr = '0; ls_wdata = '0;
    m_reset();
    m_g = 0;

    // Reset then idle
    cyc(); cyc();
    rst_f = 1;
    for (int i = 0; i < 10; i++) cyc();
    chk("idle_busy", busy, 0);
    chk("idle_rdata", rdata, 0);

    // IF read
    xfer(0, 0, 16'h0010, '0, lat, en_cnt, we_cnt);
    chk("ifrd_lat", lat, 3);
    chk("ifrd_en_cycles", en_cnt, 2);
    chk("ifrd_data", rdata, 32'hDEADBEEF);
    cyc();

    // LS store, then read it back
    xfer(1, 1, 16'h0020, 32'h12345678, lat, en_cnt, we_cnt);
    chk("st_we_cycles", we_cnt, 2);
    chk("st_rdata_hold", rdata, 32'hDEADBEEF);
    cyc();
    xfer(0, 0, 16'h0020, '0, lat, en_cnt, we_cnt);
    chk("st_readback", rdata, 32'h12345678);
    cyc();

    // Contention: LS first, then IF
    if_req = 1; if_addr = 16'h0010;
    ls_req = 1; ls_we = 0; ls_addr = 16'h0030;
    run_acks(2, 0, 0);
    if (ack_log.size() >= 2) begin
      chk("cont_first_ls", ack_log[0], 1);
      chk("cont_second_if", ack_log[1], 0);
    end
    cyc();

    // Starvation: both held high
    if_req = 1; if_addr = 16'h0011;
    ls_req = 1; ls_we = 0; ls_addr = 16'h0031;
    run_acks(8, 1, 1);
    if_req = 0; ls_req = 0;
    if (ack_log.size() >= 8) begin
      for (int i = 0; i < 8; i++) chk("starve_order", ack_log[i], exp_order[i]);
    end
    cyc(); cyc();

    // Reset in the second ACCESS cycle of an IF read
    if_req = 1; if_addr = 16'h0040;
    cyc(); cyc();
    rst_f = 0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_mem_en", mem_en, 0);
    chk("mrst_if_ack", if_ack, 0);
    chk("mrst_rdata", rdata, 0);
    m_reset();
    cyc(); cyc();
    rst_f = 1;
    k = n;
    run_acks(1, 0, 0);
    chk("mrst_relat", n - k, 3);
    chk("mrst_redata", rdata, 32'hCAFEF00D);
    if_req = 0;
    cyc();

    // Randomized traffic from two well-behaved requesters
    for (int c = 0; c < 3000; c++) begin
      cyc();
      if (if_ack) if_req = 0;
      else if (!if_req && $urandom_range(0, 3) == 0) begin
        if_req  = 1;
        if_addr = 16'($urandom_range(0, 31));
      end
      if (ls_ack) ls_req = 0;
      else if (!ls_req && $urandom_range(0, 2) == 0) begin
        ls_req   = 1;
        ls_we    = 1'($urandom_range(0, 1));
        ls_addr  = 16'($urandom_range(0, 31));
        ls_wdata = $urandom;
      end
    end
    if_req = 0; ls_req = 0;
    for (int i = 0; i < 10; i++) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
